// File: rtl/vga_rom_arbiter_if.sv
// Bus bundle between the two ROM requesters, the shared ROM and vga_rom_arbiter.
// slave = arbiter view; master = requester/ROM environment view.
interface vga_rom_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
);
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic              gnt0;
    logic              rvalid0;
    logic [DATA_W-1:0] rdata0;
    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic              gnt1;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata1;
    logic              rom_rd;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    modport slave (
        input  req0, addr0, req1, addr1, rom_data,
        output gnt0, gnt1, rvalid0, rdata0, rvalid1, rdata1, rom_rd, rom_addr
    );

    modport master (
        output req0, addr0, req1, addr1, rom_data,
        input  gnt0, gnt1, rvalid0, rdata0, rvalid1, rdata1, rom_rd, rom_addr
    );
endinterface

// File: rtl/vga_rom_arbiter.sv
// Shares one synchronous ROM between the VGA pixel fetch (port 0, priority) and an
// auxiliary loader (port 1, starvation-guarded); read data is routed back by owner tag.
module vga_rom_arbiter #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 8,
    parameter int ROM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    vga_rom_arbiter_if.slave   bus
);
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    logic [7:0]        starve_cnt;
    logic              force1;
    logic              gnt0;
    logic              gnt1;
    logic              rom_rd;
    logic [ADDR_W-1:0] rom_addr;
    logic [ROM_LAT:0]  tag_valid;
    logic [ROM_LAT:0]  tag_owner;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;

    // Port 1 wins only when port 0 is idle or port 1 has waited STARVE_MAX cycles.
    always_comb begin
        force1 = bus.req1 && (STARVE_LIM != 8'd0) && (starve_cnt == STARVE_LIM);
        gnt1   = bus.req1 && (!bus.req0 || force1);
        gnt0   = bus.req0 && !gnt1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 8'd0;
        end else if (gnt1 || !bus.req1) begin
            starve_cnt <= 8'd0;
        end else if (bus.req0 && starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_rd    <= 1'b0;
            rom_addr  <= '0;
            tag_valid <= '0;
            tag_owner <= '0;
        end else begin
            rom_rd    <= gnt0 || gnt1;
            if (gnt0 || gnt1) begin
                rom_addr <= gnt1 ? bus.addr1 : bus.addr0;
            end
            tag_valid <= {tag_valid[ROM_LAT-1:0], gnt0 || gnt1};
            tag_owner <= {tag_owner[ROM_LAT-1:0], gnt1};
        end
    end

    // The last tag stage lines up with rom_data of the same read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= tag_valid[ROM_LAT] && !tag_owner[ROM_LAT];
            rvalid1 <= tag_valid[ROM_LAT] && tag_owner[ROM_LAT];
            if (tag_valid[ROM_LAT] && !tag_owner[ROM_LAT]) begin
                rdata0 <= bus.rom_data;
            end
            if (tag_valid[ROM_LAT] && tag_owner[ROM_LAT]) begin
                rdata1 <= bus.rom_data;
            end
        end
    end

    assign bus.gnt0     = gnt0;
    assign bus.gnt1     = gnt1;
    assign bus.rom_rd   = rom_rd;
    assign bus.rom_addr = rom_addr;
    assign bus.rvalid0  = rvalid0;
    assign bus.rvalid1  = rvalid1;
    assign bus.rdata0   = rdata0;
    assign bus.rdata1   = rdata1;
endmodule

// File: tb/tb_vga_rom_arbiter.sv
// Directed bench for vga_rom_arbiter: dut_a uses STARVE_MAX=4, dut_b uses STARVE_MAX=0,
// both with ROM_LAT=1 and a behavioural one-cycle ROM.
`timescale 1ns/1ps
module tb_vga_rom_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   rv0_a;
    int   rv1_a;
    int   rv0_b;
    int   rv1_b;

    vga_rom_arbiter_if #(.ADDR_W(11), .DATA_W(8)) bus_a ();
    vga_rom_arbiter_if #(.ADDR_W(11), .DATA_W(8)) bus_b ();

    vga_rom_arbiter #(.ADDR_W(11), .DATA_W(8), .ROM_LAT(1), .STARVE_MAX(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    vga_rom_arbiter #(.ADDR_W(11), .DATA_W(8), .ROM_LAT(1), .STARVE_MAX(0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    function automatic logic [7:0] rom_fn(input logic [10:0] a);
        return a[7:0] ^ {a[10:8], 5'b10110};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle synchronous ROM for each instance.
    always @(posedge clk) begin
        bus_a.rom_data <= rom_fn(bus_a.rom_addr);
        bus_b.rom_data <= rom_fn(bus_b.rom_addr);
    end

    always @(negedge clk) begin
        if (bus_a.rvalid0 === 1'b1) rv0_a = rv0_a + 1;
        if (bus_a.rvalid1 === 1'b1) rv1_a = rv1_a + 1;
        if (bus_b.rvalid0 === 1'b1) rv0_b = rv0_b + 1;
        if (bus_b.rvalid1 === 1'b1) rv1_b = rv1_b + 1;
    end

    task automatic test_reset();
        int s0, s1;
        rst_n = 1'b0;
        bus_a.req0 = 1'b0; bus_a.req1 = 1'b0; bus_a.addr0 = '0; bus_a.addr1 = '0;
        bus_b.req0 = 1'b0; bus_b.req1 = 1'b0; bus_b.addr0 = '0; bus_b.addr1 = '0;
        #1000;
        checks++; if (bus_a.rom_rd !== 1'b0) begin errors++; $display("[TB] FAIL reset_rom_rd got %b want 0", bus_a.rom_rd); end
        checks++; if (bus_a.rom_addr !== 11'h000) begin errors++; $display("[TB] FAIL reset_rom_addr got %h want 000", bus_a.rom_addr); end
        checks++; if ({bus_a.rvalid0, bus_a.rvalid1} !== 2'b00) begin errors++; $display("[TB] FAIL reset_rvalid got %b want 00", {bus_a.rvalid0, bus_a.rvalid1}); end
        checks++; if ({bus_a.rdata0, bus_a.rdata1} !== 16'h0000) begin errors++; $display("[TB] FAIL reset_rdata got %h want 0000", {bus_a.rdata0, bus_a.rdata1}); end
        checks++; if (bus_b.rom_rd !== 1'b0) begin errors++; $display("[TB] FAIL reset_b_rom_rd got %b want 0", bus_b.rom_rd); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        s0 = rv0_a; s1 = rv1_a;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (bus_a.rom_rd !== 1'b0) begin errors++; $display("[TB] FAIL idle_rom_rd cycle %0d got %b want 0", i, bus_a.rom_rd); end
        end
        checks++; if ((rv0_a - s0) + (rv1_a - s1) != 0) begin errors++; $display("[TB] FAIL idle_rvalid got %0d pulses want 0", (rv0_a - s0) + (rv1_a - s1)); end
    endtask

    task automatic test_single_port0();
        @(posedge clk); #1;
        bus_a.req0 = 1'b1; bus_a.addr0 = 11'h010;
        #1;
        checks++; if ({bus_a.gnt0, bus_a.gnt1} !== 2'b10) begin errors++; $display("[TB] FAIL single_gnt got %b want 10", {bus_a.gnt0, bus_a.gnt1}); end
        @(posedge clk); #1;
        bus_a.req0 = 1'b0;
        checks++; if (bus_a.rom_rd !== 1'b1) begin errors++; $display("[TB] FAIL single_rom_rd got %b want 1", bus_a.rom_rd); end
        checks++; if (bus_a.rom_addr !== 11'h010) begin errors++; $display("[TB] FAIL single_rom_addr got %h want 010", bus_a.rom_addr); end
        checks++; if (bus_a.rvalid0 !== 1'b0) begin errors++; $display("[TB] FAIL single_early_rvalid_t1 got %b want 0", bus_a.rvalid0); end
        @(posedge clk); #1;
        checks++; if (bus_a.rvalid0 !== 1'b0) begin errors++; $display("[TB] FAIL single_early_rvalid_t2 got %b want 0", bus_a.rvalid0); end
        @(posedge clk); #1;
        checks++; if (bus_a.rvalid0 !== 1'b1) begin errors++; $display("[TB] FAIL single_rvalid0 got %b want 1", bus_a.rvalid0); end
        checks++; if (bus_a.rdata0 !== rom_fn(11'h010)) begin errors++; $display("[TB] FAIL single_rdata0 got %h want %h", bus_a.rdata0, rom_fn(11'h010)); end
        checks++; if (bus_a.rvalid1 !== 1'b0) begin errors++; $display("[TB] FAIL single_rvalid1 got %b want 0", bus_a.rvalid1); end
        @(posedge clk); #1;
        checks++; if (bus_a.rvalid0 !== 1'b0) begin errors++; $display("[TB] FAIL single_pulse_width got %b want 0", bus_a.rvalid0); end
    endtask

    task automatic test_contention();
        int s0, s1;
        logic want1;
        s0 = rv0_a; s1 = rv1_a;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            bus_a.req0 = 1'b1; bus_a.req1 = 1'b1;
            bus_a.addr0 = 11'(32'h100 + i); bus_a.addr1 = 11'(32'h200 + i);
            #1;
            want1 = (i == 5) || (i == 10);
            checks++; if ({bus_a.gnt0, bus_a.gnt1} !== {~want1, want1}) begin errors++; $display("[TB] FAIL contention_gnt cycle %0d got %b want %b", i, {bus_a.gnt0, bus_a.gnt1}, {~want1, want1}); end
        end
        @(posedge clk); #1;
        bus_a.req0 = 1'b0; bus_a.req1 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (rv0_a - s0 != 10) begin errors++; $display("[TB] FAIL contention_rvalid0_count got %0d want 10", rv0_a - s0); end
        checks++; if (rv1_a - s1 != 2) begin errors++; $display("[TB] FAIL contention_rvalid1_count got %0d want 2", rv1_a - s1); end
        checks++; if (bus_a.rdata0 !== rom_fn(11'h10C)) begin errors++; $display("[TB] FAIL contention_rdata0 got %h want %h", bus_a.rdata0, rom_fn(11'h10C)); end
        checks++; if (bus_a.rdata1 !== rom_fn(11'h20A)) begin errors++; $display("[TB] FAIL contention_rdata1 got %h want %h", bus_a.rdata1, rom_fn(11'h20A)); end
    endtask

    task automatic test_starve_drop();
        logic want1;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            bus_a.req0 = 1'b1; bus_a.req1 = (k != 3);
            bus_a.addr0 = 11'(32'h300 + k); bus_a.addr1 = 11'(32'h400 + k);
            #1;
            want1 = (k == 8);
            checks++; if (bus_a.gnt1 !== want1) begin errors++; $display("[TB] FAIL starve_drop_gnt1 cycle %0d got %b want %b", k, bus_a.gnt1, want1); end
        end
        @(posedge clk); #1;
        bus_a.req0 = 1'b0; bus_a.req1 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (bus_a.rdata1 !== rom_fn(11'h408)) begin errors++; $display("[TB] FAIL starve_drop_rdata1 got %h want %h", bus_a.rdata1, rom_fn(11'h408)); end
    endtask

    task automatic test_back_to_back();
        logic want_v;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            want_v = (k >= 3) && (k <= 10);
            checks++; if (bus_a.rvalid1 !== want_v) begin errors++; $display("[TB] FAIL b2b_rvalid1 cycle %0d got %b want %b", k, bus_a.rvalid1, want_v); end
            if (want_v) begin
                checks++; if (bus_a.rdata1 !== rom_fn(11'(k - 3))) begin errors++; $display("[TB] FAIL b2b_rdata1 cycle %0d got %h want %h", k, bus_a.rdata1, rom_fn(11'(k - 3))); end
            end
            bus_a.req0 = 1'b0;
            bus_a.req1 = (k < 8);
            bus_a.addr1 = 11'(k);
            #1;
            checks++; if (bus_a.gnt1 !== (k < 8)) begin errors++; $display("[TB] FAIL b2b_gnt1 cycle %0d got %b want %b", k, bus_a.gnt1, (k < 8)); end
        end
        checks++; if (bus_a.rdata0 !== rom_fn(11'h307)) begin errors++; $display("[TB] FAIL b2b_rdata0_hold got %h want %h", bus_a.rdata0, rom_fn(11'h307)); end
    endtask

    task automatic test_reset_midflight();
        int s0, s1;
        @(posedge clk); #1;
        bus_a.req0 = 1'b1; bus_a.addr0 = 11'h033; bus_a.req1 = 1'b0;
        @(posedge clk); #1;
        bus_a.req0 = 1'b0;
        s0 = rv0_a; s1 = rv1_a;
        rst_n = 1'b0;
        #1;
        checks++; if (bus_a.rom_rd !== 1'b0) begin errors++; $display("[TB] FAIL midflight_rom_rd got %b want 0", bus_a.rom_rd); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++; if ((rv0_a - s0) + (rv1_a - s1) != 0) begin errors++; $display("[TB] FAIL midflight_rvalid got %0d pulses want 0", (rv0_a - s0) + (rv1_a - s1)); end
        checks++; if (bus_a.rdata0 !== 8'h00) begin errors++; $display("[TB] FAIL midflight_rdata0 got %h want 00", bus_a.rdata0); end
    endtask

    task automatic test_starve_zero();
        int n1;
        int n0;
        int s1;
        n1 = 0; n0 = 0;
        s1 = rv1_b;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            bus_b.req0 = 1'b1; bus_b.req1 = 1'b1;
            bus_b.addr0 = 11'(32'h500 + i); bus_b.addr1 = 11'(32'h600 + i);
            #1;
            if (bus_b.gnt1 === 1'b1) n1++;
            if (bus_b.gnt0 === 1'b1) n0++;
        end
        checks++; if (n1 != 0) begin errors++; $display("[TB] FAIL starve_zero_gnt1 got %0d grants want 0", n1); end
        checks++; if (n0 != 20) begin errors++; $display("[TB] FAIL starve_zero_gnt0 got %0d grants want 20", n0); end
        checks++; if (dut_b.starve_cnt !== 8'd0) begin errors++; $display("[TB] FAIL starve_zero_cnt got %0d want 0", dut_b.starve_cnt); end
        @(posedge clk); #1;
        bus_b.req0 = 1'b0;
        #1;
        checks++; if (bus_b.gnt1 !== 1'b1) begin errors++; $display("[TB] FAIL starve_zero_idle0_gnt1 got %b want 1", bus_b.gnt1); end
        @(posedge clk); #1;
        bus_b.req1 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (rv1_b - s1 != 1) begin errors++; $display("[TB] FAIL starve_zero_rvalid1 got %0d pulses want 1", rv1_b - s1); end
        checks++; if (bus_b.rdata1 !== rom_fn(11'h613)) begin errors++; $display("[TB] FAIL starve_zero_rdata1 got %h want %h", bus_b.rdata1, rom_fn(11'h613)); end
    endtask

    initial begin
        checks = 0; errors = 0;
        rv0_a = 0; rv1_a = 0; rv0_b = 0; rv1_b = 0;
        test_reset();
        test_single_port0();
        test_contention();
        test_starve_drop();
        test_back_to_back();
        test_reset_midflight();
        test_starve_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
